// File: rtl/hexload_pkg.sv
// Shared types for the HEX loader memory writer: address width, FIFO entry layout
// and the request FSM state encoding.
package hexload_pkg;

  localparam int HEX_ADDR_W  = 22;
  localparam int HEX_ENTRY_W = HEX_ADDR_W + 8;

  typedef struct packed {
    logic [HEX_ADDR_W-1:0] addr;
    logic [7:0]            data;
  } hex_entry_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } hex_state_e;

endpackage

// File: rtl/hexload_mem_writer_if.sv
// Board memory write port: one byte per req/ack transaction.
interface hexload_mem_writer_if
  import hexload_pkg::*;
#(
  parameter int ADDR_W = HEX_ADDR_W
);

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_ack;

  modport master (
    output mem_req,
    output mem_addr,
    output mem_data,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    input  mem_data,
    output mem_ack
  );

endinterface

// File: rtl/hexload_fifo.sv
// Single-clock FIFO with one extra pointer bit to tell full from empty.
// A push while full is accepted only when a pop happens on the same edge.
module hexload_fifo
  import hexload_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = HEX_ENTRY_W
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok_s  = pop_i & ~empty_o;
  assign push_ok_s = push_i & (~full_o | pop_ok_s);
  assign head_o    = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; both wrap naturally through the extra MSB.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Storage; when full with a same-edge pop, the written slot is the one being freed.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/hexload_mem_writer.sv
// Buffers parser byte writes in a FIFO and drains them to board memory over req/ack,
// reporting busy, a sticky overflow flag and a count of acknowledged bytes.
module hexload_mem_writer
  import hexload_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = HEX_ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n,
  input  logic                 ce_i,
  input  logic                 wr_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [7:0]           data_i,
  hexload_mem_writer_if.master mem_bus,
  output logic                 busy_o,
  output logic                 overflow_o,
  output logic [CNT_W-1:0]     count_o
);

  localparam int ENTRY_W = ADDR_W + 8;

  logic               push_s;
  logic               pop_s;
  logic               full_s;
  logic               empty_s;
  logic [ENTRY_W-1:0] wr_entry_s;
  logic [ENTRY_W-1:0] head_s;

  hex_state_e         state_q;
  logic               req_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [7:0]         data_q;
  logic               ovf_q;
  logic               ovf_d;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;

  assign push_s     = wr_i & ce_i;
  assign pop_s      = (state_q == REQ) & mem_bus.mem_ack;
  assign wr_entry_s = {addr_i, data_i};

  hexload_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .data_i  (wr_entry_s),
    .head_o  (head_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // Status next state: overflow only when a full FIFO cannot make room this edge.
  always_comb begin
    ovf_d   = ovf_q;
    count_d = count_q;
    if (push_s && full_s && !pop_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
    if (pop_s) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Status registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

  // Request FSM; the head entry stays in the FIFO until the memory acknowledges it.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty_s) begin
            addr_q  <= head_s[ENTRY_W-1:8];
            data_q  <= head_s[7:0];
            req_q   <= 1'b1;
            state_q <= REQ;
          end else begin
            req_q   <= 1'b0;
          end
        end
        REQ: begin
          if (mem_bus.mem_ack) begin
            req_q   <= 1'b0;
            state_q <= IDLE;
          end else begin
            req_q   <= 1'b1;
          end
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_bus.mem_req  = req_q;
  assign mem_bus.mem_addr = addr_q;
  assign mem_bus.mem_data = data_q;
  assign busy_o           = ~empty_s | (state_q == REQ);
  assign overflow_o       = ovf_q;
  assign count_o          = count_q;

endmodule
